ex_mdu: RTL
===========

# ex_mdu

Parametrised iterative multiply/divide unit implementing the RV32M (and RV64M-width-ready) R-type `funct7 = 7'b0000001` operations, placed alongside the execute stage. The decode/execute path hands it one operation through a start handshake. It holds the pipeline through `ctrl_stall` while iterating, then presents a one-cycle write-back (`we`/`waddr`/`wdata`) for the register file. Throughput and area trade off through `UNROLL`.

## Interface
- `XLEN`, default 32: operand/result width; must be a multiple of `UNROLL`.
- `UNROLL`, default 1: multiply/divide bits retired per iteration cycle; legal values are 1, 2, 4.
- `REG_AW`, default 5: register address width.
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `start`  in  1: operation request; sampled only in IDLE.
- `funct3`  in  3: operation select (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU = 0..7).
- `reg1`  in  XLEN: rs1 operand (multiplicand or dividend).
- `reg2`  in  XLEN: rs2 operand (multiplier or divisor).
- `reg_waddr`  in  REG_AW: destination register.
- `flush`  in  1: abort the in-flight operation (branch/jump taken upstream).
- `busy`  out  1: registered; high while not in IDLE.
- `ctrl_stall`  out  1: combinational; `(start & idle) | (state == CALC)`.
- `we`  out  1: registered; high for exactly one cycle in DONE.
- `waddr`  out  REG_AW: registered destination, valid when `we`.
- `wdata`  out  XLEN: registered result, valid when `we`.

## Operation
- States: IDLE, CALC, DONE.
- IDLE, `start` high:
  - Capture `funct3` and `reg_waddr`.
  - Capture operands as magnitudes plus sign flags. Signed treatment: MULH takes both operands signed; MULHSU takes rs1 signed only; DIV/REM take both signed. MUL, MULHU, DIVU, REMU are unsigned.
  - Go to CALC.
- CALC:
  - Multiply: shift-add into a 2·XLEN accumulator, `UNROLL` bits per cycle.
  - Divide: restoring division, `UNROLL` quotient bits per cycle, XLEN+1-bit partial remainder.
  - The iteration counter runs 0..XLEN/UNROLL−1. At the terminal count go to DONE.
- Sign fix-up happens on the transition into DONE:
  - Product is negated if the operand signs differ.
  - Quotient is negated if the signs differ; remainder takes the dividend's sign.
- Result select:
  - MUL → product[XLEN−1:0].
  - MULH/MULHSU/MULHU → product[2XLEN−1:XLEN].
  - DIV/DIVU → quotient; REM/REMU → remainder.
- Special cases bypass CALC (IDLE → DONE directly):
  - Divisor zero: DIV/DIVU → all ones; REM/REMU → dividend.
  - Signed overflow (dividend = −2^(XLEN−1), divisor = −1, DIV/REM only): DIV → −2^(XLEN−1); REM → 0.
- DONE: assert `we` with `waddr`/`wdata`, then return to IDLE.
- `start` while not in IDLE is ignored. Upstream must hold `start` and the operands until `ctrl_stall` falls.
- `flush` in any state: go to IDLE next edge, no `we`. `flush` and `start` together in IDLE: start is dropped.
- All arithmetic is modulo 2^XLEN; no exceptions are raised.

## Timing
- Reset values: state IDLE, `busy` 0, `we` 0, `waddr` 0, `wdata` 0, counter 0, accumulators 0. `ctrl_stall` is 0 while `rst` is high.
- Let cycle 0 be the cycle in which `start` is high in IDLE.
  - `ctrl_stall` is high in cycle 0 through cycle N, where N = XLEN/UNROLL.
  - CALC occupies cycles 1..N.
  - DONE (`we` = 1) falls in cycle N+1, with `ctrl_stall` low so the pipeline advances.
  - Default (32/1): `we` in cycle 33. With UNROLL = 4: cycle 9.
- Special cases: `we` in cycle 1; `ctrl_stall` high in cycle 0 only.
- Back-to-back: a new `start` is accepted in the cycle after DONE. Minimum issue interval is N+2 cycles.
- `rst` asserted mid-CALC clears all state asynchronously. No `we` is issued for the aborted operation.

## Structure
- Shared package (alongside the existing defines):
  - `FUNCT7_MULDIV` = 7'b0000001.
  - The eight `FUNC3_M_*` encodings.
  - MDU state encoding (IDLE/CALC/DONE).
- One sub-module, `mdu_div_step`: combinational, one restoring-division step (trial subtract, quotient bit, new remainder). It is instantiated `UNROLL` times in a chain.
- The multiply step stays inline.

## Test plan
- MUL 7 × 0xFFFFFFFD (−3) → `wdata` 0xFFFFFFEB, `we` in cycle 33, `ctrl_stall` high in cycles 0–32.
- MULH 0x80000000 × 0x80000000 → 0x40000000; MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE; MULHSU 0xFFFFFFFF × 2 → 0xFFFFFFFF.
- DIV 0xFFFFFFF9 (−7) / 2 → 0xFFFFFFFD; REM → 0xFFFFFFFF; DIVU 100 / 7 → 14; REMU → 2.
- DIV 5 / 0 → 0xFFFFFFFF and REM 5 / 0 → 5, both with `we` in cycle 1. DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM → 0.
- `flush` in cycle 10 of a DIVU → no `we`, `busy` low in cycle 11. Then `start` a MUL 3 × 4 → 12 in cycle 45 relative to the new start's cycle 0 + 33.
- `rst` pulsed in cycle 5 of a MUL → `busy`/`we`/`wdata` immediately 0, no `we` afterwards. Repeat the suite with UNROLL = 2 and 4, checking latency 17/9.

Source files
------------

// File: rtl/ex_mdu_pkg.sv
// Shared M-extension encodings and MDU state constants.
// Also holds the per-operation signedness decode used by the multiply/divide unit.
package ex_mdu_pkg;

  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  localparam logic [2:0] FUNC3_M_MUL    = 3'd0;
  localparam logic [2:0] FUNC3_M_MULH   = 3'd1;
  localparam logic [2:0] FUNC3_M_MULHSU = 3'd2;
  localparam logic [2:0] FUNC3_M_MULHU  = 3'd3;
  localparam logic [2:0] FUNC3_M_DIV    = 3'd4;
  localparam logic [2:0] FUNC3_M_DIVU   = 3'd5;
  localparam logic [2:0] FUNC3_M_REM    = 3'd6;
  localparam logic [2:0] FUNC3_M_REMU   = 3'd7;

  localparam logic [1:0] MDU_IDLE = 2'd0;
  localparam logic [1:0] MDU_CALC = 2'd1;
  localparam logic [1:0] MDU_DONE = 2'd2;

  function automatic logic op_signed_a(input logic [2:0] f3);
    return (f3 == FUNC3_M_MULH) || (f3 == FUNC3_M_MULHSU) ||
           (f3 == FUNC3_M_DIV)  || (f3 == FUNC3_M_REM);
  endfunction

  function automatic logic op_signed_b(input logic [2:0] f3);
    return (f3 == FUNC3_M_MULH) || (f3 == FUNC3_M_DIV) || (f3 == FUNC3_M_REM);
  endfunction

endpackage

// File: rtl/ex_mdu_if.sv
// Issue/write-back bundle between the execute stage and the MDU.
// master = execute stage, slave = ex_mdu.
interface ex_mdu_if #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
);
  logic              start;
  logic [2:0]        funct3;
  logic [XLEN-1:0]   reg1;
  logic [XLEN-1:0]   reg2;
  logic [REG_AW-1:0] reg_waddr;
  logic              flush;
  logic              busy;
  logic              ctrl_stall;
  logic              we;
  logic [REG_AW-1:0] waddr;
  logic [XLEN-1:0]   wdata;

  modport master (
    output start, funct3, reg1, reg2, reg_waddr, flush,
    input  busy, ctrl_stall, we, waddr, wdata
  );

  modport slave (
    input  start, funct3, reg1, reg2, reg_waddr, flush,
    output busy, ctrl_stall, we, waddr, wdata
  );
endinterface

// File: rtl/ex_mdu_div_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract the divisor.
// The remainder entering a step is always below the divisor, so it fits in XLEN bits.
module mdu_div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem_in,
  input  logic            dividend_bit,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] rem_out,
  output logic            q_bit
);
  logic [XLEN:0]   shifted;
  logic [XLEN-1:0] diff;

  always_comb begin
    shifted = {rem_in, dividend_bit};
    q_bit   = (shifted >= {1'b0, divisor});
    // Only taken when shifted >= divisor, so the difference is below 2^XLEN.
    diff    = shifted[XLEN-1:0] - divisor;
    rem_out = q_bit ? diff : shifted[XLEN-1:0];
  end
endmodule

// File: rtl/ex_mdu.sv
// Iterative RV32M/RV64M multiply/divide unit, UNROLL bits per cycle.
// Holds the pipeline via ctrl_stall while iterating, then issues a one-cycle write-back.
module ex_mdu
  import ex_mdu_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int UNROLL = 1,
  parameter int REG_AW = 5
) (
  input  logic    clk,
  input  logic    rst,
  ex_mdu_if.slave bus
);
  localparam int N     = XLEN / UNROLL;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  logic [1:0]          state_reg;
  logic [CNT_W-1:0]    cnt_reg;
  logic [2:0]          f3_reg;
  logic [XLEN-1:0]     opa_reg;
  logic [2*XLEN-1:0]   acc_reg;
  logic [XLEN-1:0]     quo_reg;
  logic [XLEN-1:0]     rem_reg;
  logic                neg_res_reg;
  logic                neg_rem_reg;
  logic                busy_reg;
  logic                we_reg;
  logic [REG_AW-1:0]   waddr_reg;
  logic [XLEN-1:0]     wdata_reg;

  logic                neg_a, neg_b, is_div, div_zero, div_ovf, idle;
  logic [XLEN-1:0]     mag_a, mag_b, special_res;

  assign idle           = (state_reg == MDU_IDLE);
  assign bus.busy       = busy_reg;
  assign bus.we         = we_reg;
  assign bus.waddr      = waddr_reg;
  assign bus.wdata      = wdata_reg;
  assign bus.ctrl_stall = ~rst & ((bus.start & idle) | (state_reg == MDU_CALC));

  // Operand capture: magnitudes plus sign flags, and the CALC-bypassing corner cases.
  always_comb begin
    is_div   = bus.funct3[2];
    neg_a    = op_signed_a(bus.funct3) & bus.reg1[XLEN-1];
    neg_b    = op_signed_b(bus.funct3) & bus.reg2[XLEN-1];
    mag_a    = neg_a ? -bus.reg1 : bus.reg1;
    mag_b    = neg_b ? -bus.reg2 : bus.reg2;
    div_zero = is_div & (bus.reg2 == '0);
    div_ovf  = is_div & ~bus.funct3[0] & (bus.reg1 == INT_MIN) & (bus.reg2 == '1);
    if (div_zero) special_res = bus.funct3[1] ? bus.reg1 : '1;
    else          special_res = bus.funct3[1] ? '0 : INT_MIN;
  end

  // Shift-add multiply: low half starts as the multiplier and drains as product bits enter.
  logic [XLEN:0]     mul_hi;
  logic [XLEN-1:0]   mul_lo;
  logic [2*XLEN-1:0] mul_next;

  always_comb begin
    mul_hi = {1'b0, acc_reg[2*XLEN-1:XLEN]};
    mul_lo = acc_reg[XLEN-1:0];
    for (int i = 0; i < UNROLL; i++) begin
      if (mul_lo[0]) mul_hi = mul_hi + {1'b0, opa_reg};
      mul_lo = {mul_hi[0], mul_lo[XLEN-1:1]};
      mul_hi = mul_hi >> 1;
    end
    mul_next = {mul_hi[XLEN-1:0], mul_lo};
  end

  genvar gi;
  generate
    for (gi = 0; gi < UNROLL; gi++) begin : g_div
      logic [XLEN-1:0] r_in, r_out, q_in, q_out;
      logic            qb;
      if (gi == 0) begin : g_first
        assign r_in = rem_reg;
        assign q_in = quo_reg;
      end else begin : g_next
        assign r_in = g_div[gi-1].r_out;
        assign q_in = g_div[gi-1].q_out;
      end
      mdu_div_step #(.XLEN(XLEN)) u_step (
        .rem_in      (r_in),
        .dividend_bit(q_in[XLEN-1]),
        .divisor     (opa_reg),
        .rem_out     (r_out),
        .q_bit       (qb)
      );
      assign q_out = {q_in[XLEN-2:0], qb};
    end
  endgenerate

  logic [XLEN-1:0]   quo_next, rem_next, quo_fix, rem_fix, calc_res;
  logic [2*XLEN-1:0] prod_fix;

  assign quo_next = g_div[UNROLL-1].q_out;
  assign rem_next = g_div[UNROLL-1].r_out;

  always_comb begin
    prod_fix = neg_res_reg ? -mul_next : mul_next;
    quo_fix  = neg_res_reg ? -quo_next : quo_next;
    rem_fix  = neg_rem_reg ? -rem_next : rem_next;
    case (f3_reg)
      FUNC3_M_MUL:                                 calc_res = prod_fix[XLEN-1:0];
      FUNC3_M_MULH, FUNC3_M_MULHSU, FUNC3_M_MULHU: calc_res = prod_fix[2*XLEN-1:XLEN];
      FUNC3_M_DIV, FUNC3_M_DIVU:                   calc_res = quo_fix;
      default:                                     calc_res = rem_fix;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= MDU_IDLE;
      cnt_reg     <= '0;
      f3_reg      <= '0;
      opa_reg     <= '0;
      acc_reg     <= '0;
      quo_reg     <= '0;
      rem_reg     <= '0;
      neg_res_reg <= 1'b0;
      neg_rem_reg <= 1'b0;
      busy_reg    <= 1'b0;
      we_reg      <= 1'b0;
      waddr_reg   <= '0;
      wdata_reg   <= '0;
    end else begin
      we_reg <= 1'b0;
      if (bus.flush) begin
        state_reg <= MDU_IDLE;
        busy_reg  <= 1'b0;
        cnt_reg   <= '0;
      end else begin
        case (state_reg)
          MDU_IDLE: if (bus.start) begin
            f3_reg      <= bus.funct3;
            waddr_reg   <= bus.reg_waddr;
            opa_reg     <= is_div ? mag_b : mag_a;
            acc_reg     <= {{XLEN{1'b0}}, mag_b};
            quo_reg     <= mag_a;
            rem_reg     <= '0;
            neg_res_reg <= neg_a ^ neg_b;
            neg_rem_reg <= neg_a;
            cnt_reg     <= '0;
            busy_reg    <= 1'b1;
            if (div_zero | div_ovf) begin
              state_reg <= MDU_DONE;
              we_reg    <= 1'b1;
              wdata_reg <= special_res;
            end else begin
              state_reg <= MDU_CALC;
            end
          end
          MDU_CALC: begin
            acc_reg <= mul_next;
            quo_reg <= quo_next;
            rem_reg <= rem_next;
            cnt_reg <= cnt_reg + 1'b1;
            if (cnt_reg == CNT_W'(N - 1)) begin
              state_reg <= MDU_DONE;
              we_reg    <= 1'b1;
              wdata_reg <= calc_res;
              cnt_reg   <= '0;
            end
          end
          default: begin
            state_reg <= MDU_IDLE;
            busy_reg  <= 1'b0;
          end
        endcase
      end
    end
  end
endmodule
